// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants, pacing FSM state encoding and frame-length helper.
// Contents: BPS_CNT_2M, UART_FRAME_BITS, IDLE/STROBE/GAP states, frame_clks().
package uart_pkg;
    localparam int BPS_CNT_2M      = 25;
    localparam int UART_FRAME_BITS = 10;
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] STROBE  = 2'd1;
    localparam logic [1:0] GAP     = 2'd2;
    function automatic int frame_clks(input int bps_cnt, input int guard_clks);
        return UART_FRAME_BITS * bps_cnt + guard_clks;
    endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: registered-pointer FIFO, no fall-through, full/empty from pointer compare.
// Ports: clk, rst_n (async active-low), wr_en_i/wr_data_i push, rd_en_i pop,
//        rd_data_o head entry, full_o, empty_o.
module sync_fifo import uart_pkg::*; #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int ADDR_W = $clog2(DEPTH);
    logic [ADDR_W:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push, pop;
    // Extra pointer MSB distinguishes full (wrapped once) from empty.
    assign full_o    = (wr_ptr_q ^ rd_ptr_q) == {1'b1, {ADDR_W{1'b0}}};
    assign empty_o   = wr_ptr_q == rd_ptr_q;
    assign push      = wr_en_i && !full_o;
    assign pop       = rd_en_i && !empty_o;
    assign wr_ptr_d  = wr_ptr_q + {{ADDR_W{1'b0}}, push};
    assign rd_ptr_d  = rd_ptr_q + {{ADDR_W{1'b0}}, pop};
    assign rd_data_o = mem_q[rd_ptr_q[ADDR_W-1:0]];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[ADDR_W-1:0]] <= wr_data_i;
    end
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO plus pacing FSM feeding a busy-less UART transmitter.
// Ports: sys_clk, sys_rst_n (async active-low), wr_en/wr_data push, full, empty, busy,
//        uart_send (rising edge starts a frame), uart_data (byte for the frame).
// Optional UART_TX_FIFO_OVF_EN adds tx_ovf (sticky dropped-push flag) and ovf_clr.
module uart_tx_fifo import uart_pkg::*; #(
    parameter int DEPTH       = 16,
    parameter int BPS_CNT     = BPS_CNT_2M,
    parameter int STROBE_CLKS = 4,
    parameter int GUARD_CLKS  = 4
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       full,
    output logic       empty,
    output logic       busy,
    output logic       uart_send,
    output logic [7:0] uart_data
`ifdef UART_TX_FIFO_OVF_EN
    ,
    output logic       tx_ovf,
    input  logic       ovf_clr
`endif
);
    localparam int FRAME_CLKS = frame_clks(BPS_CNT, GUARD_CLKS);
    localparam int CNT_W      = $clog2(FRAME_CLKS + 1);
    localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(STROBE_CLKS - 1);
    localparam logic [CNT_W-1:0] FRAME_LAST  = CNT_W'(FRAME_CLKS - 1);
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       data_q, data_d, rd_data;
    logic             send_q, send_d, pop;
    sync_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
        .clk       (sys_clk),
        .rst_n     (sys_rst_n),
        .wr_en_i   (wr_en),
        .wr_data_i (wr_data),
        .rd_en_i   (pop),
        .rd_data_o (rd_data),
        .full_o    (full),
        .empty_o   (empty)
    );
    // cnt runs from the pop through STROBE and GAP, so one compare bounds the whole frame.
    always_comb begin
        pop     = state_q == IDLE && !empty;
        state_d = pop                                       ? STROBE :
                  (state_q == STROBE && cnt_q == STROBE_LAST) ? GAP    :
                  (state_q == GAP && cnt_q == FRAME_LAST)     ? IDLE   : state_q;
        cnt_d   = pop ? '0 : (state_q == IDLE) ? cnt_q : cnt_q + 1'b1;
        data_d  = pop ? rd_data : data_q;
        // Registered strobe: uart_send rises one cycle after entering STROBE.
        send_d  = state_q == STROBE;
    end
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            send_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            send_q  <= send_d;
        end
    end
    assign uart_send = send_q;
    assign uart_data = data_q;
    assign busy      = !empty || state_q != IDLE;
`ifdef UART_TX_FIFO_OVF_EN
    logic ovf_q, ovf_d;
    // A dropped push in the same cycle as ovf_clr keeps the flag set.
    assign ovf_d = (wr_en && full) ? 1'b1 : ovf_clr ? 1'b0 : ovf_q;
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) ovf_q <= 1'b0;
        else            ovf_q <= ovf_d;
    end
    assign tx_ovf = ovf_q;
`endif
endmodule
